// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline hazard query and stall control bundle
// master = pipeline side driving stage info, slave = hazard_stall_unit
interface hazard_stall_unit_if #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 32
) ();
    logic                     ext_stall;
    logic                     flush;
    logic                     id_valid;
    logic [NUM_SRC*REG_W-1:0] id_src;
    logic [NUM_SRC-1:0]       id_src_use;
    logic                     id_is_branch;
    logic                     id_mdu_start;
    logic                     id_uses_hilo;
    logic                     ex_valid;
    logic                     ex_wr_en;
    logic                     ex_mem_read;
    logic [REG_W-1:0]         ex_rd;
    logic                     mem_valid;
    logic                     mem_wr_en;
    logic                     mem_mem_read;
    logic [REG_W-1:0]         mem_rd;
    logic                     PC_write;
    logic                     IF_ID_write;
    logic                     stall_info;
    logic                     mdu_busy;
    logic [2:0]               stall_cause;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output ext_stall, flush, id_valid, id_src, id_src_use, id_is_branch,
               id_mdu_start, id_uses_hilo, ex_valid, ex_wr_en, ex_mem_read, ex_rd,
               mem_valid, mem_wr_en, mem_mem_read, mem_rd,
        input  PC_write, IF_ID_write, stall_info, mdu_busy, stall_cause, stall_cnt
    );

    modport slave (
        input  ext_stall, flush, id_valid, id_src, id_src_use, id_is_branch,
               id_mdu_start, id_uses_hilo, ex_valid, ex_wr_en, ex_mem_read, ex_rd,
               mem_valid, mem_wr_en, mem_mem_read, mem_rd,
        output PC_write, IF_ID_write, stall_info, mdu_busy, stall_cause, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use, branch-in-ID and MDU hazard detector with stall control
// Owns the MDU occupancy tracker and a saturating bubble-cycle counter.
module hazard_stall_unit #(
    parameter int REG_W        = 5,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_LAT     = 2,
    parameter int MDU_LAT      = 32,
    parameter int BRANCH_IN_ID = 1,
    parameter int CNT_W        = 32
) (
    input logic                 clk,
    input logic                 rst,
    hazard_stall_unit_if.slave  bus
);
    localparam int MW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t       state, state_nxt;
    logic [MW-1:0]    mdu_cnt, mdu_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;

    logic [NUM_SRC-1:0] m_ex;
    logic [NUM_SRC-1:0] m_mem;
    logic               load_ex, load_mem;
    logic               load_haz, branch_haz, mdu_haz;
    logic               mdu_busy;
    logic               hz;
    logic               mdu_accept;

    // Register 0 is hardwired, so it never creates a dependency.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_match
        logic [REG_W-1:0] src_k;
        assign src_k    = bus.id_src[k*REG_W +: REG_W];
        assign m_ex[k]  = bus.id_src_use[k] & bus.ex_valid & bus.ex_wr_en &
                          (bus.ex_rd == src_k) & (src_k != '0);
        assign m_mem[k] = bus.id_src_use[k] & bus.mem_valid & bus.mem_wr_en &
                          (bus.mem_rd == src_k) & (src_k != '0);
    end

    assign load_ex    = (|m_ex) & bus.ex_mem_read;
    assign load_mem   = (LOAD_LAT >= 2) ? ((|m_mem) & bus.mem_mem_read) : 1'b0;
    assign load_haz   = load_ex | load_mem;
    // A branch compares in ID, so even a plain ALU result still in EX is too late.
    assign branch_haz = (BRANCH_IN_ID != 0) ? (bus.id_is_branch & (|m_ex) & ~bus.ex_mem_read) : 1'b0;
    assign mdu_busy   = (state == BUSY);
    assign mdu_haz    = bus.id_uses_hilo & mdu_busy;

    assign hz = rst & bus.id_valid & ~bus.flush & ~bus.ext_stall &
                (load_haz | branch_haz | mdu_haz);

    assign mdu_accept = bus.id_mdu_start & bus.id_valid & ~hz & ~bus.flush & ~bus.ext_stall;

    always_comb begin
        bus.PC_write    = 1'b1;
        bus.IF_ID_write = 1'b1;
        bus.stall_info  = 1'b0;
        bus.stall_cause = 3'b000;
        if (hz) begin
            bus.PC_write    = 1'b0;
            bus.IF_ID_write = 1'b0;
            bus.stall_info  = 1'b1;
            if (load_haz)
                bus.stall_cause = 3'b001;
            else if (branch_haz)
                bus.stall_cause = 3'b010;
            else
                bus.stall_cause = 3'b100;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // The MDU keeps counting through ext_stall and flush; only reset aborts it.
    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        case (state)
            IDLE: begin
                if (mdu_accept) begin
                    state_nxt   = BUSY;
                    mdu_cnt_nxt = MW'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                if (mdu_cnt == '0)
                    state_nxt = IDLE;
                else
                    mdu_cnt_nxt = mdu_cnt - MW'(1);
            end
            default: begin
                state_nxt   = IDLE;
                mdu_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (hz && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign bus.mdu_busy  = mdu_busy;
    assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed checks of hazard_stall_unit in two configurations
// ua: LOAD_LAT=2, BRANCH_IN_ID=1; ub: LOAD_LAT=1, BRANCH_IN_ID=0; both MDU_LAT=4, CNT_W=4.
module tb_hazard_stall_unit;
    logic clk;
    logic rst;

    logic       ext_stall, flush, id_valid;
    logic [9:0] id_src;
    logic [1:0] id_src_use;
    logic       id_is_branch, id_mdu_start, id_uses_hilo;
    logic       ex_valid, ex_wr_en, ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_wr_en, mem_mem_read;
    logic [4:0] mem_rd;

    int checks;
    int errors;

    hazard_stall_unit_if #(.REG_W(5), .NUM_SRC(2), .CNT_W(4)) ia ();
    hazard_stall_unit_if #(.REG_W(5), .NUM_SRC(2), .CNT_W(4)) ib ();

    assign ia.ext_stall    = ext_stall;    assign ib.ext_stall    = ext_stall;
    assign ia.flush        = flush;        assign ib.flush        = flush;
    assign ia.id_valid     = id_valid;     assign ib.id_valid     = id_valid;
    assign ia.id_src       = id_src;       assign ib.id_src       = id_src;
    assign ia.id_src_use   = id_src_use;   assign ib.id_src_use   = id_src_use;
    assign ia.id_is_branch = id_is_branch; assign ib.id_is_branch = id_is_branch;
    assign ia.id_mdu_start = id_mdu_start; assign ib.id_mdu_start = id_mdu_start;
    assign ia.id_uses_hilo = id_uses_hilo; assign ib.id_uses_hilo = id_uses_hilo;
    assign ia.ex_valid     = ex_valid;     assign ib.ex_valid     = ex_valid;
    assign ia.ex_wr_en     = ex_wr_en;     assign ib.ex_wr_en     = ex_wr_en;
    assign ia.ex_mem_read  = ex_mem_read;  assign ib.ex_mem_read  = ex_mem_read;
    assign ia.ex_rd        = ex_rd;        assign ib.ex_rd        = ex_rd;
    assign ia.mem_valid    = mem_valid;    assign ib.mem_valid    = mem_valid;
    assign ia.mem_wr_en    = mem_wr_en;    assign ib.mem_wr_en    = mem_wr_en;
    assign ia.mem_mem_read = mem_mem_read; assign ib.mem_mem_read = mem_mem_read;
    assign ia.mem_rd       = mem_rd;       assign ib.mem_rd       = mem_rd;

    hazard_stall_unit #(
        .REG_W(5), .NUM_SRC(2), .LOAD_LAT(2), .MDU_LAT(4), .BRANCH_IN_ID(1), .CNT_W(4)
    ) ua (.clk(clk), .rst(rst), .bus(ia));

    hazard_stall_unit #(
        .REG_W(5), .NUM_SRC(2), .LOAD_LAT(1), .MDU_LAT(4), .BRANCH_IN_ID(0), .CNT_W(4)
    ) ub (.clk(clk), .rst(rst), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ext_stall = 0; flush = 0; id_valid = 0; id_src = '0; id_src_use = '0;
        id_is_branch = 0; id_mdu_start = 0; id_uses_hilo = 0;
        ex_valid = 0; ex_wr_en = 0; ex_mem_read = 0; ex_rd = '0;
        mem_valid = 0; mem_wr_en = 0; mem_mem_read = 0; mem_rd = '0;
    endtask

    function automatic logic [2:0] ctl_a();
        return {ia.PC_write, ia.IF_ID_write, ia.stall_info};
    endfunction

    function automatic logic [2:0] ctl_b();
        return {ib.PC_write, ib.IF_ID_write, ib.stall_info};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        clear_in();
        tick();
        tick();
        check("rst_ctl",   32'(ctl_a()), 32'b110);
        check("rst_cause", 32'(ia.stall_cause), 32'b000);
        check("rst_busy",  32'(ia.mdu_busy), 32'd0);
        check("rst_cnt",   32'(ia.stall_cnt), 32'd0);
        rst = 1'b1;
        tick();

        // lw $8 in EX, add using $8 in ID
        id_valid = 1; id_src = {5'd0, 5'd8}; id_src_use = 2'b01;
        ex_valid = 1; ex_wr_en = 1; ex_mem_read = 1; ex_rd = 5'd8;
        #1;
        check("ld_ex_ctl_a",   32'(ctl_a()), 32'b001);
        check("ld_ex_cause_a", 32'(ia.stall_cause), 32'b001);
        check("ld_ex_ctl_b",   32'(ctl_b()), 32'b001);
        tick();
        ex_valid = 0; ex_wr_en = 0; ex_mem_read = 0; ex_rd = '0;
        mem_valid = 1; mem_wr_en = 1; mem_mem_read = 1; mem_rd = 5'd8;
        #1;
        check("ld_mem_ctl_a",   32'(ctl_a()), 32'b001);
        check("ld_mem_cause_a", 32'(ia.stall_cause), 32'b001);
        check("ld_mem_ctl_b",   32'(ctl_b()), 32'b110);
        tick();
        clear_in();
        #1;
        check("ld_cnt_a", 32'(ia.stall_cnt), 32'd2);
        check("ld_cnt_b", 32'(ib.stall_cnt), 32'd1);

        // $0 never hazards
        id_valid = 1; id_src = {5'd0, 5'd0}; id_src_use = 2'b01;
        ex_valid = 1; ex_wr_en = 1; ex_mem_read = 1; ex_rd = 5'd0;
        #1;
        check("r0_ctl_a", 32'(ctl_a()), 32'b110);
        // add $9 in EX, beq on $9 (operand 1)
        ex_mem_read = 0; ex_rd = 5'd9; id_src = {5'd9, 5'd3}; id_src_use = 2'b10;
        id_is_branch = 1;
        #1;
        check("br_ctl_a",   32'(ctl_a()), 32'b001);
        check("br_cause_a", 32'(ia.stall_cause), 32'b010);
        check("br_ctl_b",   32'(ctl_b()), 32'b110);
        id_is_branch = 0;
        #1;
        check("alu_nobr_ctl_a", 32'(ctl_a()), 32'b110);
        id_is_branch = 1; ex_mem_read = 1;
        #1;
        check("ld_br_cause_a", 32'(ia.stall_cause), 32'b001);
        check("ld_br_cause_b", 32'(ib.stall_cause), 32'b001);
        clear_in();

        // mult accepted at cycle 0
        id_valid = 1; id_mdu_start = 1; id_uses_hilo = 1;
        #1;
        check("mult_acc_ctl", 32'(ctl_a()), 32'b110);
        check("mult_acc_busy", 32'(ia.mdu_busy), 32'd0);
        tick();
        id_mdu_start = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) id_mdu_start = 1;
            #1;
            check($sformatf("mfhi_busy_c%0d", c),  32'(ia.mdu_busy), 32'd1);
            check($sformatf("mfhi_ctl_c%0d", c),   32'(ctl_a()), 32'b001);
            check($sformatf("mfhi_cause_c%0d", c), 32'(ia.stall_cause), 32'b100);
            tick();
        end
        // cycle 5: idle again, the held mult now starts
        check("c5_busy", 32'(ia.mdu_busy), 32'd0);
        check("c5_ctl",  32'(ctl_a()), 32'b110);
        check("c5_cnt_a", 32'(ia.stall_cnt), 32'd6);
        check("c5_cnt_b", 32'(ib.stall_cnt), 32'd5);
        tick();
        id_mdu_start = 0; ext_stall = 1;
        for (int c = 6; c <= 9; c++) begin
            #1;
            check($sformatf("xs_busy_c%0d", c),  32'(ia.mdu_busy), 32'd1);
            check($sformatf("xs_ctl_c%0d", c),   32'(ctl_a()), 32'b110);
            check($sformatf("xs_cause_c%0d", c), 32'(ia.stall_cause), 32'b000);
            tick();
        end
        check("xs_done_busy", 32'(ia.mdu_busy), 32'd0);
        check("xs_cnt_a", 32'(ia.stall_cnt), 32'd6);
        ext_stall = 0;

        // asynchronous reset while BUSY
        id_mdu_start = 1;
        #1;
        tick();
        id_mdu_start = 0;
        #1;
        check("pre_rst_ctl", 32'(ctl_a()), 32'b001);
        tick();
        check("pre_rst_busy", 32'(ia.mdu_busy), 32'd1);
        check("pre_rst_cnt",  32'(ia.stall_cnt), 32'd7);
        rst = 0;
        #1;
        check("mid_rst_busy", 32'(ia.mdu_busy), 32'd0);
        check("mid_rst_ctl",  32'(ctl_a()), 32'b110);
        check("mid_rst_cnt",  32'(ia.stall_cnt), 32'd0);
        tick();
        clear_in();
        rst = 1;
        tick();

        // flush suppresses the stall and the count
        id_valid = 1; id_src = {5'd0, 5'd12}; id_src_use = 2'b01;
        ex_valid = 1; ex_wr_en = 1; ex_mem_read = 1; ex_rd = 5'd12; flush = 1;
        #1;
        check("flush_ctl", 32'(ctl_a()), 32'b110);
        tick();
        check("flush_cnt", 32'(ia.stall_cnt), 32'd0);
        flush = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 14) check("sat_reach_a", 32'(ia.stall_cnt), 32'd15);
        end
        check("sat_hold_a", 32'(ia.stall_cnt), 32'd15);
        check("sat_hold_b", 32'(ib.stall_cnt), 32'd15);
        check("sat_ctl_a",  32'(ctl_a()), 32'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Parametrised hazard/stall controller for the 5-stage MIPS pipeline and the next generation of the load-use detector. It compares ID-stage source registers against EX and MEM destinations and covers load-use, branch-in-ID operand and multi-cycle MDU (mult/div) hazards. It drives PC_write, IF_ID_write and stall_info (bubble into ID/EX). It also owns a sequential MDU busy tracker and a saturating stall-cycle counter.

Parameters:
REG_W, 5, register index width
NUM_SRC, 2, number of ID source operands checked
LOAD_LAT, 2, load-data latency: 1 = only a load in EX is hazardous; 2 = loads in EX and MEM are hazardous
MDU_LAT, 32, cycles an MDU operation occupies HI/LO (>=2)
BRANCH_IN_ID, 1, 1 = branches resolve in ID, so an ALU result still in EX is also a hazard for a branch
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
ext_stall  in  1  global freeze from the memory bus; when 1, this unit inserts no bubble
flush  in  1  exception/redirect; kills the ID instruction
id_valid  in  1  ID holds a valid instruction
id_src  in  NUM_SRC*REG_W  ID source register indices; operand k is at [k*REG_W +: REG_W]
id_src_use  in  NUM_SRC  per-operand read enable
id_is_branch  in  1  ID instruction is a branch or jump-register
id_mdu_start  in  1  ID instruction starts an MDU operation
id_uses_hilo  in  1  ID instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
ex_valid, ex_wr_en, ex_mem_read  in  1 each  EX-stage qualifiers
ex_rd  in  REG_W  EX destination
mem_valid, mem_wr_en, mem_mem_read  in  1 each  MEM-stage qualifiers
mem_rd  in  REG_W  MEM destination
PC_write  out  1  1 = PC may update
IF_ID_write  out  1  1 = IF/ID register may update
stall_info  out  1  1 = insert bubble into ID/EX
mdu_busy  out  1  MDU occupancy flag
stall_cause  out  3  {mdu, branch, load}, one-hot or 000
stall_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (rst=0, asynchronous): PC_write=1, IF_ID_write=1, stall_info=0, stall_cause=000, mdu_busy=0, stall_cnt=0, FSM=IDLE, MDU counter=0.
- Operand match m_k(stage): id_src_use[k] & stage_valid & stage_wr_en & (stage_rd == src_k) & (src_k != 0). Register 0 never causes a hazard.
- load_haz: any k with m_k(EX) & ex_mem_read. When LOAD_LAT=2, also any k with m_k(MEM) & mem_mem_read.
- branch_haz (BRANCH_IN_ID=1 only): id_is_branch & any k with m_k(EX) where ex_mem_read=0. It is 0 when BRANCH_IN_ID=0.
- mdu_haz: id_uses_hilo & mdu_busy.
- Cause priority: load > branch > mdu. stall_cause shows only the highest active cause.
- Stall condition: hz = id_valid & ~flush & ~ext_stall & (load_haz | branch_haz | mdu_haz).
- Outputs are combinational from inputs and state: hz=1 gives {PC_write,IF_ID_write,stall_info}=001; otherwise 110. ext_stall=1 forces 110 and stall_cause=000.
- MDU FSM, states IDLE and BUSY:
  - IDLE->BUSY on id_mdu_start & id_valid & ~hz & ~flush & ~ext_stall; counter loads MDU_LAT-1.
  - In BUSY the counter decrements every cycle, including during ext_stall, because the MDU runs independently.
  - BUSY->IDLE when counter==0 at a clock edge.
  - mdu_busy=1 exactly in BUSY, which lasts MDU_LAT cycles.
  - An id_mdu_start arriving during BUSY is blocked by mdu_haz, since id_uses_hilo=1 for mult/div.
  - flush does not abort BUSY; the in-flight operation completes.
- stall_cnt increments on each edge where hz=1 and saturates at all-ones without wrapping.
- Simultaneous events:
  - flush with hazard: no stall (110); the flushed instruction is discarded upstream.
  - Load and branch hazards together: cause 001.
  - mdu_start on the final BUSY cycle is still stalled that cycle and starts the next cycle.

Test Plan:
1. Reset mid-BUSY: drop rst after 5 BUSY cycles -> immediately mdu_busy=0, outputs 110, stall_cnt=0.
2. EX lw $8 with ID add using $8 -> 001, cause 001 for 1 cycle. Then, with the load in MEM and LOAD_LAT=2 -> 001 again; with LOAD_LAT=1 -> 110. stall_cnt=2 (LOAD_LAT=2) or 1 (LOAD_LAT=1).
3. EX lw $0 with ID use of $0 -> 110. EX add $9 with ID beq on $9 -> 001, cause 010 when BRANCH_IN_ID=1; 110 when BRANCH_IN_ID=0.
4. MDU_LAT=4: mult accepted at cycle 0 -> mdu_busy=1 for cycles 1-4. mfhi in ID at cycles 1-4 -> 001, cause 100. At cycle 5 -> 110.
5. Hazard with ext_stall=1 -> 110, cause 000, stall_cnt unchanged. MDU counter still reaches 0 on schedule.
6. CNT_W=4 with 20 consecutive stall cycles -> stall_cnt holds at 15. Hazard plus flush=1 -> 110, no increment.
